// File: rtl/tinyodin_sched_pkg.sv
// Scheduler state encoding and read/write phase helpers shared by the neuron
// event scheduler and the controller's time-reference path.
package tinyodin_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EV_RD = 3'd2,
        ST_EV_WR = 3'd3,
        ST_TR_RD = 3'd4,
        ST_TR_WR = 3'd5
    } sched_state_t;

    localparam logic PH_RD = 1'b0;
    localparam logic PH_WR = 1'b1;

    function automatic logic in_sweep(input sched_state_t s);
        return (s == ST_EV_RD) || (s == ST_EV_WR) || (s == ST_TR_RD) || (s == ST_TR_WR);
    endfunction

    function automatic logic state_phase(input sched_state_t s);
        return ((s == ST_EV_WR) || (s == ST_TR_WR)) ? PH_WR : PH_RD;
    endfunction

endpackage

// File: rtl/neuron_sweep_counter.sv
// M-bit neuron index with a latched sweep limit; wraps to 0 after the write
// that hits the limit. load_i has priority over inc_i.
import tinyodin_sched_pkg::*;

module neuron_sweep_counter #(
    parameter int M = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         inc_i,
    input  logic [M-1:0] limit_i,
    output logic [M-1:0] idx_o,
    output logic         last_o
);

    logic [M-1:0] idx_q, idx_d;
    logic [M-1:0] limit_q, limit_d;

    assign last_o = (idx_q == limit_q);
    assign idx_o  = idx_q;

    always_comb begin
        idx_d   = idx_q;
        limit_d = limit_q;
        if (load_i) begin
            limit_d = limit_i;
            idx_d   = '0;
        end else if (inc_i) begin
            // Compare happens before the increment, so limit = 2^M-1 never wraps early.
            idx_d = last_o ? '0 : idx_q + M'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q   <= '0;
            limit_q <= '0;
        end else begin
            idx_q   <= idx_d;
            limit_q <= limit_d;
        end
    end

endmodule

// File: rtl/neuron_event_scheduler.sv
// Arbitrates the neuron-state port between spike events and time-reference sweeps.
// Spike: pop, fetch, then one rd/wr pair per neuron; a pending tick wins at IDLE.
import tinyodin_sched_pkg::*;

module neuron_event_scheduler #(
    parameter int N = 256,
    parameter int M = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         enable_i,
    input  logic [M-1:0] max_neuron_i,
    input  logic         tick_i,
    input  logic         fifo_empty_i,
    input  logic [M-1:0] fifo_r_data_i,
    output logic         fifo_r_en_o,
    output logic [M-1:0] neur_idx_o,
    output logic         neur_rd_o,
    output logic         neur_wr_o,
    output logic         neur_event_o,
    output logic         neur_tref_o,
    output logic [M-1:0] src_addr_o,
    output logic         busy_o,
    output logic         tick_done_o,
    output logic         tick_overrun_o
);

    localparam logic [M-1:0] LAST_NEURON = M'(N - 1);

    sched_state_t state_q, state_d;
    logic         tick_pend_q, tick_pend_d;
    logic         overrun_q, overrun_d;
    logic [M-1:0] src_q, src_d;
    logic         tick_req;
    logic         cnt_load;
    logic         sweep_last;
    logic [M-1:0] sweep_idx;
    logic [M-1:0] limit_eff;

    // A tick arriving in IDLE is granted the same cycle, hence the bypass.
    assign tick_req  = tick_pend_q | tick_i;
    assign limit_eff = (max_neuron_i > LAST_NEURON) ? LAST_NEURON : max_neuron_i;

    neuron_sweep_counter #(.M(M)) u_cnt (
        .clk_i   (CLK),
        .rst_i   (RST),
        .load_i  (cnt_load),
        .inc_i   (neur_wr_o),
        .limit_i (limit_eff),
        .idx_o   (sweep_idx),
        .last_o  (sweep_last)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    if (tick_req) begin
                        state_d = ST_TR_RD;
                    end else if (!fifo_empty_i) begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: state_d = ST_EV_RD;
            ST_EV_RD: state_d = ST_EV_WR;
            ST_EV_WR: state_d = sweep_last ? ST_IDLE : ST_EV_RD;
            ST_TR_RD: state_d = ST_TR_WR;
            ST_TR_WR: state_d = sweep_last ? ST_IDLE : ST_TR_RD;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_r_en_o  = 1'b0;
        neur_rd_o    = 1'b0;
        neur_wr_o    = 1'b0;
        if (state_q == ST_IDLE) begin
            fifo_r_en_o = enable_i && !tick_req && !fifo_empty_i;
        end
        if (in_sweep(state_q)) begin
            neur_rd_o = (state_phase(state_q) == PH_RD);
            neur_wr_o = (state_phase(state_q) == PH_WR);
        end
        neur_event_o = (state_q == ST_EV_RD) || (state_q == ST_EV_WR);
        neur_tref_o  = (state_q == ST_TR_RD) || (state_q == ST_TR_WR);
        tick_done_o  = (state_q == ST_TR_WR) && sweep_last;
        cnt_load     = (state_q == ST_FETCH) || ((state_q == ST_IDLE) && (state_d == ST_TR_RD));
    end

    always_comb begin
        tick_pend_d = tick_pend_q;
        overrun_d   = overrun_q;
        src_d       = src_q;
        if (!enable_i) begin
            tick_pend_d = 1'b0;
            overrun_d   = 1'b0;
        end else begin
            if (tick_i && tick_pend_q) begin
                overrun_d = 1'b1;
            end
            tick_pend_d = ((state_q == ST_IDLE) && (state_d == ST_TR_RD)) ? 1'b0 : tick_req;
        end
        // Popped word is on the FIFO read port during FETCH.
        if (state_q == ST_FETCH) begin
            src_d = fifo_r_data_i;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            tick_pend_q <= 1'b0;
            overrun_q   <= 1'b0;
            src_q       <= '0;
        end else begin
            tick_pend_q <= tick_pend_d;
            overrun_q   <= overrun_d;
            src_q       <= src_d;
        end
    end

    assign neur_idx_o     = sweep_idx;
    assign src_addr_o     = src_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign tick_overrun_o = overrun_q;

endmodule

// File: tb/tb_neuron_event_scheduler.sv
// Directed bench: a cycle-level model expands each granted event into its
// expected rd/wr trace and every output is compared on every cycle.
module tb_neuron_event_scheduler;

    localparam int M = 8;

    logic         CLK;
    logic         RST;
    logic         enable_i;
    logic [M-1:0] max_neuron_i;
    logic         tick_i;
    logic         fifo_empty_i;
    logic [M-1:0] fifo_r_data_i;
    logic         fifo_r_en_o;
    logic [M-1:0] neur_idx_o;
    logic         neur_rd_o;
    logic         neur_wr_o;
    logic         neur_event_o;
    logic         neur_tref_o;
    logic [M-1:0] src_addr_o;
    logic         busy_o;
    logic         tick_done_o;
    logic         tick_overrun_o;

    neuron_event_scheduler #(.N(256), .M(M)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .enable_i       (enable_i),
        .max_neuron_i   (max_neuron_i),
        .tick_i         (tick_i),
        .fifo_empty_i   (fifo_empty_i),
        .fifo_r_data_i  (fifo_r_data_i),
        .fifo_r_en_o    (fifo_r_en_o),
        .neur_idx_o     (neur_idx_o),
        .neur_rd_o      (neur_rd_o),
        .neur_wr_o      (neur_wr_o),
        .neur_event_o   (neur_event_o),
        .neur_tref_o    (neur_tref_o),
        .src_addr_o     (src_addr_o),
        .busy_o         (busy_o),
        .tick_done_o    (tick_done_o),
        .tick_overrun_o (tick_overrun_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit fen;
        bit rd;
        bit wr;
        bit ev;
        bit tr;
        bit busy;
        bit done;
        bit fetch;
        int idx;
        int src;
    } rec_t;

    rec_t sched[$];
    int   fq[$];
    bit   m_pend;
    bit   m_ovr;
    int   m_src;
    bit   chk_on;
    int   n_cmp;
    int   n_fail;
    int   cyc_n;
    int   rd_cnt, wr_cnt, td_cnt, tr_cnt;
    int   b_rd, b_wr, b_td, b_tr;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d act=0x%0h exp=0x%0h", nm, cyc_n, act, exp);
        end
    endtask

    task automatic add_sweep(input bit is_ev, input int lim);
        rec_t r;
        for (int i = 0; i <= lim; i++) begin
            r = '{default: 0};
            r.busy = 1'b1;
            r.ev   = is_ev;
            r.tr   = !is_ev;
            r.idx  = i;
            r.rd   = 1'b1;
            sched.push_back(r);
            r.rd   = 1'b0;
            r.wr   = 1'b1;
            r.done = !is_ev && (i == lim);
            sched.push_back(r);
        end
    endtask

    task automatic model_check();
        rec_t e;
        rec_t f;
        bit   granted_tr;
        e = '{default: 0};
        granted_tr = 1'b0;
        if (sched.size() != 0) begin
            e = sched.pop_front();
        end else if (enable_i) begin
            if (m_pend || tick_i) begin
                add_sweep(1'b0, int'(max_neuron_i));
                granted_tr = 1'b1;
            end else if (!fifo_empty_i && fq.size() > 0) begin
                e.fen = 1'b1;
                f = '{default: 0};
                f.busy  = 1'b1;
                f.fetch = 1'b1;
                f.src   = fq[0];
                sched.push_back(f);
                add_sweep(1'b1, int'(max_neuron_i));
            end
        end
        chk("fifo_r_en", int'(fifo_r_en_o), int'(e.fen));
        chk("idx", int'(neur_idx_o), e.idx);
        chk("rd", int'(neur_rd_o), int'(e.rd));
        chk("wr", int'(neur_wr_o), int'(e.wr));
        chk("event", int'(neur_event_o), int'(e.ev));
        chk("tref", int'(neur_tref_o), int'(e.tr));
        chk("busy", int'(busy_o), int'(e.busy));
        chk("tick_done", int'(tick_done_o), int'(e.done));
        chk("src_addr", int'(src_addr_o), m_src);
        chk("overrun", int'(tick_overrun_o), int'(m_ovr));
        rd_cnt += int'(neur_rd_o);
        wr_cnt += int'(neur_wr_o);
        td_cnt += int'(tick_done_o);
        tr_cnt += int'(neur_tref_o && neur_rd_o);
        if (e.fetch) m_src = e.src;
        if (!enable_i) begin
            m_pend = 1'b0;
            m_ovr  = 1'b0;
        end else begin
            if (tick_i && m_pend) m_ovr = 1'b1;
            m_pend = granted_tr ? 1'b0 : (m_pend || tick_i);
        end
        if (RST) begin
            sched.delete();
            m_pend = 1'b0;
            m_ovr  = 1'b0;
            m_src  = 0;
        end
    endtask

    task automatic cyc();
        bit pop_now;
        @(negedge CLK);
        if (chk_on) model_check();
        pop_now = fifo_r_en_o;
        @(posedge CLK);
        #1;
        cyc_n++;
        if (pop_now && fq.size() > 0) begin
            fifo_r_data_i = M'(fq.pop_front());
            fifo_empty_i  = (fq.size() == 0);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic push(input int w);
        fq.push_back(w);
        fifo_empty_i = 1'b0;
    endtask

    task automatic tick_pulse();
        tick_i = 1'b1;
        cyc();
        tick_i = 1'b0;
    endtask

    task automatic settle(input int budget);
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (!busy_o && sched.size() == 0 && fifo_empty_i && !m_pend) return;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL settle_timeout cyc=%0d act=busy exp=idle within %0d", cyc_n, budget);
    endtask

    task automatic mark();
        b_rd = rd_cnt;
        b_wr = wr_cnt;
        b_td = td_cnt;
        b_tr = tr_cnt;
    endtask

    initial begin
        RST           = 1'b1;
        enable_i      = 1'b1;
        max_neuron_i  = 8'd3;
        tick_i        = 1'b0;
        fifo_empty_i  = 1'b1;
        fifo_r_data_i = '0;
        chk_on        = 1'b0;
        n_cmp = 0; n_fail = 0; cyc_n = 0;
        rd_cnt = 0; wr_cnt = 0; td_cnt = 0; tr_cnt = 0;
        m_pend = 1'b0; m_ovr = 1'b0; m_src = 0;

        cyc();
        chk_on = 1'b1;
        cyc();
        RST = 1'b0;
        cyc();
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_idx", int'(neur_idx_o), 0);
        chk("reset_src", int'(src_addr_o), 0);
        chk("reset_ovr", int'(tick_overrun_o), 0);

        // single spike, limit 3
        push(8'h2A);
        cyc();
        chk("t1_fetch_busy", int'(busy_o), 1);
        chk("t1_fetch_rd", int'(neur_rd_o), 0);
        cyc();
        chk("t1_src", int'(src_addr_o), 8'h2A);
        chk("t1_first_rd", int'(neur_rd_o), 1);
        chk("t1_first_idx", int'(neur_idx_o), 0);
        for (int k = 1; k < 8; k++) begin
            cyc();
            chk("t1_idx", int'(neur_idx_o), k / 2);
            chk("t1_wr", int'(neur_wr_o), k % 2);
            chk("t1_event", int'(neur_event_o), 1);
        end
        cyc();
        chk("t1_idle_busy", int'(busy_o), 0);
        chk("t1_idle_idx", int'(neur_idx_o), 0);

        // tick and spike together: TREF first, then the pop
        mark();
        push(8'h11);
        tick_i = 1'b1;
        cyc();
        tick_i = 1'b0;
        chk("t2_tref_first", int'(neur_tref_o), 1);
        chk("t2_rd", int'(neur_rd_o), 1);
        settle(100);
        chk("t2_src", int'(src_addr_o), 8'h11);
        chk("t2_done_cnt", td_cnt - b_td, 1);
        chk("t2_wr_cnt", wr_cnt - b_wr, 8);

        // one tick during a spike sweep
        max_neuron_i = 8'd7;
        mark();
        push(8'h05);
        cycles(4);
        tick_pulse();
        settle(200);
        chk("t3_tref_rd_cnt", tr_cnt - b_tr, 8);
        chk("t3_ovr", int'(tick_overrun_o), 0);

        // two ticks in one sweep: overrun, single TREF sweep
        mark();
        push(8'h06);
        cycles(3);
        tick_pulse();
        cycles(2);
        tick_pulse();
        settle(200);
        chk("t4_ovr", int'(tick_overrun_o), 1);
        chk("t4_done_cnt", td_cnt - b_td, 1);
        chk("t4_tref_rd_cnt", tr_cnt - b_tr, 8);

        // limit 0
        max_neuron_i = 8'd0;
        mark();
        push(8'h33);
        settle(50);
        chk("t5_rd_cnt", rd_cnt - b_rd, 1);
        chk("t5_wr_cnt", wr_cnt - b_wr, 1);

        // limit 255: all 256 neurons
        max_neuron_i = 8'd255;
        mark();
        push(8'hFF);
        settle(600);
        chk("t6_rd_cnt", rd_cnt - b_rd, 256);
        chk("t6_wr_cnt", wr_cnt - b_wr, 256);
        chk("t6_idx_after", int'(neur_idx_o), 0);

        // max_neuron_i changed mid-sweep is ignored
        max_neuron_i = 8'd4;
        mark();
        push(8'h44);
        cycles(4);
        max_neuron_i = 8'd1;
        settle(100);
        chk("t7_wr_cnt", wr_cnt - b_wr, 5);

        // disable mid-sweep
        max_neuron_i = 8'd3;
        mark();
        push(8'h55);
        push(8'h56);
        cycles(2);
        tick_pulse();
        cyc();
        tick_pulse();
        chk("t8_ovr_set", int'(tick_overrun_o), 1);
        enable_i = 1'b0;
        cycles(5);
        tick_pulse();
        cycles(4);
        chk("t8_wr_cnt", wr_cnt - b_wr, 4);
        chk("t8_no_pop", int'(fifo_empty_i), 0);
        chk("t8_ovr_clr", int'(tick_overrun_o), 0);
        chk("t8_no_tref", tr_cnt - b_tr, 0);
        enable_i = 1'b1;
        settle(100);
        chk("t8_src", int'(src_addr_o), 8'h56);
        chk("t8_no_tref_after", tr_cnt - b_tr, 0);

        // reset during EV_WR idx 5
        max_neuron_i = 8'd7;
        push(8'h77);
        cycles(13);
        chk("t9_wr", int'(neur_wr_o), 1);
        chk("t9_idx", int'(neur_idx_o), 5);
        RST = 1'b1;
        cyc();
        chk("t9_busy", int'(busy_o), 0);
        chk("t9_idx0", int'(neur_idx_o), 0);
        chk("t9_wr0", int'(neur_wr_o), 0);
        chk("t9_rd0", int'(neur_rd_o), 0);
        chk("t9_ev0", int'(neur_event_o), 0);
        chk("t9_src0", int'(src_addr_o), 0);
        chk("t9_fen0", int'(fifo_r_en_o), 0);
        RST = 1'b0;
        cyc();

        // lone tick in IDLE: TR_RD next cycle
        max_neuron_i = 8'd2;
        mark();
        tick_pulse();
        chk("t10_tref", int'(neur_tref_o), 1);
        chk("t10_rd", int'(neur_rd_o), 1);
        chk("t10_idx", int'(neur_idx_o), 0);
        settle(50);
        chk("t10_done_cnt", td_cnt - b_td, 1);
        chk("t10_wr_cnt", wr_cnt - b_wr, 3);
        cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
